pc_sequencer: RTL and testbench

//  Fetch sequencer that drives the Program_Counter PS[1:0]/PC_IN controls.

---
 rtl/pc_sequencer.sv | 153 +++++++++++++++
 tb/tb_pc_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch sequencer driving Program_Counter PS/PC_IN; one instruction per FETCH->ISSUE round trip.
// PS/PC_IN are Mealy outputs of the current state; stall parks the issue point in STALLED until released.
module pc_sequencer #(
  parameter int ADDR_W    = 64,
  parameter int CNT_W     = 32,
  parameter int FETCH_TMO = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              br_valid,
  input  logic              br_abs,
  input  logic [ADDR_W-1:0] br_target,
  output logic [1:0]        PS,
  output logic [ADDR_W-1:0] PC_IN,
  output logic              fetch_req,
  output logic              instr_valid,
  output logic              busy,
  output logic              fault,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int TMO_W = (FETCH_TMO > 1) ? $clog2(FETCH_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_STALLED,
    S_FAULT
  } state_t;

  state_t             state_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               fault_q;
  logic [CNT_W-1:0]   ret_q;
  logic               lbr_vld_q;
  logic               lbr_abs_q;
  logic [ADDR_W-1:0]  lbr_tgt_q;

  logic [1:0]         ps_d;
  logic [ADDR_W-1:0]  pc_in_d;

  // PC control is combinational so the counter moves on the same edge that leaves ISSUE/STALLED.
  always_comb begin
    ps_d    = 2'b00;
    pc_in_d = '0;
    case (state_q)
      S_ISSUE: begin
        if (!halt && !stall) begin
          if (br_valid) begin
            ps_d    = br_abs ? 2'b10 : 2'b11;
            pc_in_d = br_target;
          end else begin
            ps_d = 2'b01;
          end
        end
      end
      S_STALLED: begin
        if (!halt && !stall) begin
          if (lbr_vld_q) begin
            ps_d    = lbr_abs_q ? 2'b10 : 2'b11;
            pc_in_d = lbr_tgt_q;
          end else begin
            ps_d = 2'b01;
          end
        end
      end
      default: begin
        ps_d    = 2'b00;
        pc_in_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      fault_q   <= 1'b0;
      ret_q     <= '0;
      lbr_vld_q <= 1'b0;
      lbr_abs_q <= 1'b0;
      lbr_tgt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            tmo_q   <= '0;
          end
        end
        S_FETCH: begin
          if (fetch_ready) begin
            state_q <= S_ISSUE;
            tmo_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_ISSUE: begin
          if (halt) begin
            state_q <= S_IDLE;
            ret_q   <= ret_q + 1'b1;
          end else if (stall) begin
            // Retirement waits until the stall releases; the branch decision is frozen here.
            state_q   <= S_STALLED;
            lbr_vld_q <= br_valid;
            lbr_abs_q <= br_abs;
            lbr_tgt_q <= br_target;
          end else begin
            state_q <= S_FETCH;
            ret_q   <= ret_q + 1'b1;
          end
        end
        S_STALLED: begin
          if (halt || !stall) begin
            state_q   <= halt ? S_IDLE : S_FETCH;
            ret_q     <= ret_q + 1'b1;
            lbr_vld_q <= 1'b0;
            lbr_abs_q <= 1'b0;
            lbr_tgt_q <= '0;
          end
        end
        S_FAULT: begin
          if (start) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
            tmo_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign PS          = ps_d;
  assign PC_IN       = pc_in_d;
  assign fetch_req   = (state_q == S_FETCH);
  assign instr_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_STALLED);
  assign fault       = fault_q;
  assign retired_cnt = ret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: transaction-level driver feeds a reference of PC arithmetic
// and retire counts into a queue; a negedge monitor checks each PC-update / issue event.
module tb_pc_sequencer;
  localparam int AW  = 64;
  localparam int CW  = 32;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset, start, halt, stall, fetch_ready, br_valid, br_abs;
  logic [AW-1:0] br_target;
  logic [1:0]    PS;
  logic [AW-1:0] PC_IN;
  logic          fetch_req, instr_valid, busy, fault;
  logic [CW-1:0] retired_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(AW), .CNT_W(CW), .FETCH_TMO(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .fetch_ready(fetch_ready), .br_valid(br_valid), .br_abs(br_abs), .br_target(br_target),
    .PS(PS), .PC_IN(PC_IN), .fetch_req(fetch_req), .instr_valid(instr_valid),
    .busy(busy), .fault(fault), .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic          iv;
    logic [1:0]    ps;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] pc_after;
    logic [CW-1:0] ret_before;
  } exp_t;

  exp_t          expq[$];
  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] ref_pc = '0;
  logic [AW-1:0] tb_pc = '0;
  logic [CW-1:0] ref_ret = '0;
  logic [AW-1:0] mon_nxt;
  exp_t          mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: models Program_Counter from PS/PC_IN and pops one expectation per event.
  always @(negedge clk) begin
    if (reset === 1'b1 && (instr_valid === 1'b1 || PS !== 2'b00)) begin
      case (PS)
        2'b01:   mon_nxt = tb_pc + 1;
        2'b10:   mon_nxt = PC_IN;
        2'b11:   mon_nxt = tb_pc + PC_IN;
        default: mon_nxt = tb_pc;
      endcase
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got iv=%0b PS=%0b with empty queue at %0t", instr_valid, PS, $time);
      end else begin
        mon_e = expq.pop_front();
        check("instr_valid", {63'd0, instr_valid}, {63'd0, mon_e.iv});
        check("PS", {62'd0, PS}, {62'd0, mon_e.ps});
        check("PC_IN", PC_IN, mon_e.pc_in);
        check("pc_after", mon_nxt, mon_e.pc_after);
        check("retired_before", {32'd0, retired_cnt}, {32'd0, mon_e.ret_before});
      end
      tb_pc = mon_nxt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; stall = 0; fetch_ready = 0;
    br_valid = 0; br_abs = 0; br_target = '0;
  endtask

  task automatic garbage_ctl();
    br_valid  = 1'($urandom);
    br_abs    = 1'($urandom);
    br_target = {$urandom, $urandom};
  endtask

  task automatic push_retire(input bit is_br, input logic babs, input logic [AW-1:0] tgt, input logic iv);
    exp_t e;
    e.iv = iv;
    e.ret_before = ref_ret;
    if (is_br) begin
      e.ps       = babs ? 2'b10 : 2'b11;
      e.pc_in    = tgt;
      e.pc_after = babs ? tgt : ref_pc + tgt;
    end else begin
      e.ps       = 2'b01;
      e.pc_in    = '0;
      e.pc_after = ref_pc + 1;
    end
    expq.push_back(e);
    ref_pc = e.pc_after;
    ref_ret++;
  endtask

  task automatic push_hold_issue();
    exp_t e;
    e.iv = 1'b1; e.ps = 2'b00; e.pc_in = '0; e.pc_after = ref_pc; e.ret_before = ref_ret;
    expq.push_back(e);
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // kind: 0 plain, 1 branch, 2 halt, 3 halt with branch. Returns with DUT in FETCH unless halted.
  task automatic do_instr(input int lat, input int kind, input int nstall, input logic babs,
                          input logic [AW-1:0] tgt, input bit halt_in_stall);
    for (int i = 0; i < lat; i++) begin
      fetch_ready = 0; garbage_ctl(); halt = 1'($urandom); stall = 1'($urandom); start = 1'($urandom);
      tick();
    end
    fetch_ready = 1; garbage_ctl(); halt = 1'($urandom); stall = 1'($urandom); start = 1'($urandom);
    tick();
    fetch_ready = 1'($urandom); start = 1'($urandom);
    halt = (kind >= 2); stall = (nstall > 0);
    br_valid = (kind == 1 || kind == 3); br_abs = babs; br_target = tgt;
    if (kind >= 2) begin
      push_hold_issue();
      ref_ret++;
      tick();
    end else if (nstall > 0) begin
      push_hold_issue();
      tick();
      for (int i = 1; i < nstall; i++) begin
        halt = 0; stall = 1; garbage_ctl();
        tick();
      end
      garbage_ctl();
      if (halt_in_stall) begin
        halt = 1; stall = 1'($urandom);
        ref_ret++;
      end else begin
        halt = 0; stall = 0;
        push_retire(kind == 1, babs, tgt, 1'b0);
      end
      tick();
    end else begin
      push_retire(kind == 1, babs, tgt, 1'b1);
      tick();
    end
    clear_inputs();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_retired"}, {32'd0, retired_cnt}, {32'd0, ref_ret});
  endtask

  initial begin
    int n;
    bit in_fetch;
    clear_inputs();
    reset = 0;
    repeat (3) tick();
    reset = 1;
    tick();
    check("rst_PS", {62'd0, PS}, 64'd0);
    check("rst_PC_IN", PC_IN, 64'd0);
    check("rst_fetch_req", {63'd0, fetch_req}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_fault", {63'd0, fault}, 64'd0);
    check("rst_retired", {32'd0, retired_cnt}, 64'd0);

    // Three plain instructions with two-cycle fetch latency.
    do_start();
    check("start_fetch_req", {63'd0, fetch_req}, 64'd1);
    check("start_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 3; i++) do_instr(2, 0, 0, 1'b0, '0, 1'b0);
    check("seq_pc", tb_pc, 64'd3);
    check("seq_retired", {32'd0, retired_cnt}, 64'd3);

    do_instr(1, 1, 0, 1'b1, 64'h40, 1'b0);
    check("abs_pc", tb_pc, 64'h40);
    do_instr(0, 1, 4, 1'b0, -64'sd2, 1'b0);
    check("rel_pc", tb_pc, 64'h3e);
    do_instr(TMO - 1, 0, 0, 1'b0, '0, 1'b0);
    check("late_ready_fault", {63'd0, fault}, 64'd0);
    do_instr(0, 0, 2, 1'b0, '0, 1'b0);
    do_instr(1, 3, 0, 1'b1, 64'h99, 1'b0);
    check_idle("halt_br");
    do_start();
    do_instr(2, 1, 3, 1'b1, 64'h10, 1'b1);
    check_idle("halt_stall");
    check("halt_stall_pc", tb_pc, 64'h40);

    do_start();
    in_fetch = 1;
    for (int it = 0; it < 150; it++) begin
      int k;
      if (!in_fetch) begin do_start(); in_fetch = 1; end
      k = $urandom_range(0, 9);
      if (k < 4) begin
        do_instr($urandom_range(0, 6), 0, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                 1'b0, '0, 1'b0);
      end else if (k < 8) begin
        do_instr($urandom_range(0, 6), 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                 1'($urandom), {$urandom, $urandom}, 1'b0);
      end else if (k == 8) begin
        do_instr($urandom_range(0, 6), 2 + $urandom_range(0, 1), 0, 1'($urandom), {$urandom, $urandom}, 1'b0);
        check_idle("rnd_halt");
        in_fetch = 0;
      end else begin
        do_instr($urandom_range(0, 6), $urandom_range(0, 1), $urandom_range(1, 4), 1'($urandom),
                 {$urandom, $urandom}, 1'b1);
        check_idle("rnd_halt_stall");
        in_fetch = 0;
      end
    end

    // Fetch timeout.
    if (!in_fetch) do_start();
    n = 0;
    while (fetch_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("tmo_cycles", n, TMO);
    check("tmo_fault", {63'd0, fault}, 64'd1);
    check("tmo_busy", {63'd0, busy}, 64'd0);
    check("tmo_fetch_req", {63'd0, fetch_req}, 64'd0);
    tick();
    check("fault_sticky", {63'd0, fault}, 64'd1);
    do_start();
    check("fault_clear", {63'd0, fault}, 64'd0);
    check("fault_refetch", {63'd0, fetch_req}, 64'd1);
    do_instr(0, 0, 0, 1'b0, '0, 1'b0);

    // Asynchronous reset in the middle of a FETCH cycle.
    #2;
    reset = 0;
    #1;
    check("arst_PS", {62'd0, PS}, 64'd0);
    check("arst_PC_IN", PC_IN, 64'd0);
    check("arst_fetch_req", {63'd0, fetch_req}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_retired", {32'd0, retired_cnt}, 64'd0);
    ref_ret = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'($urandom); fetch_ready = 1'($urandom); stall = 1'($urandom); garbage_ctl();
      #1;
      check("arst_hold_PS", {62'd0, PS}, 64'd0);
    end
    clear_inputs();
    tick();
    reset = 1;
    tick();
    do_start();
    do_instr(1, 0, 0, 1'b0, '0, 1'b0);
    do_instr(0, 2, 0, 1'b0, '0, 1'b0);
    check_idle("post_rst");

    repeat (2) tick();
    check("queue_empty", expq.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
